spi_master_tx: RTL and testbench
================================

Name: spi_master_tx

Overview:
- SPI mode-0 master transmitter. It is the initiator end of the MOSI/SCK/nCS link that the iCE40 target uses to load code.
- Accepts bytes over a valid/ready stream and serialises them MSB-first on MOSI. Frames are delimited by nCS.
- Used in the host/programmer-side FPGA and in the testbench to drive the target's SPI input.
- Transmit only; there is no MISO.

Parameters:
- CLK_DIV, 4: SCK half-period in clk cycles (>=1).
- CS_SETUP, 2: clk cycles nCS is low before the first SCK low phase of a frame (>=1).
- CS_HOLD, 2: clk cycles nCS stays low after the last SCK falling edge of a frame (>=1).
- CS_GAP, 2: minimum clk cycles nCS is high between frames (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- in_data  in  8  byte to send
- in_last  in  1  byte ends the frame; sampled with in_data
- in_valid  in  1  in_data/in_last valid
- in_ready  out  1  block accepts a byte this cycle
- MOSI  out  1  serial data, MSB first
- SCK  out  1  serial clock, idles low
- nCS  out  1  chip select, active low
- busy  out  1  high whenever nCS is low or the block is in GAP
- byte_done  out  1  one-cycle pulse per transmitted byte

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk. All outputs are registered except in_ready.
- Reset values: nCS=1, SCK=0, MOSI=0, busy=0, byte_done=0, state=IDLE. in_ready=0 while reset is high.
- in_ready is combinational from state: 1 in IDLE and NEXT, 0 otherwise. It does not depend on in_valid.
- Accept occurs on the clk edge where in_valid & in_ready. On accept, the block latches in_data into the shift register and latches in_last.
- States:
  - IDLE: nCS=1, SCK=0, MOSI=0.
    - On accept: go to SETUP; nCS=0 and MOSI=data[7] from the next cycle.
  - SETUP: lasts CS_SETUP cycles, SCK=0. Then go to SHIFT.
  - SHIFT: 8 bits, MSB first. Per bit:
    - low phase: SCK=0 for CLK_DIV cycles, MOSI = current bit.
    - high phase: SCK=1 for CLK_DIV cycles, MOSI unchanged.
    - MOSI changes only when SCK goes low, so it is stable across every rising edge.
    - One byte takes 16*CLK_DIV cycles. After the 8th high phase, SCK returns to 0 and byte_done pulses in that same cycle.
    - Next state: HOLD if the latched last=1, else NEXT.
  - NEXT: nCS=0, SCK=0, MOSI holds bit 0.
    - Waits indefinitely for in_valid (stall allowed).
    - On accept: go to SHIFT, starting the bit-7 low phase the next cycle. No setup delay.
  - HOLD: CS_HOLD cycles with nCS=0, SCK=0. Then nCS=1, MOSI=0, go to GAP.
  - GAP: CS_GAP cycles with nCS=1. Then go to IDLE.
- Minimum frame length (single byte) is CS_SETUP + 16*CLK_DIV + CS_HOLD cycles of nCS low.
- Bytes back-to-back within a frame add 1 NEXT cycle between bytes when in_valid is already high.
- Counters: bit counter 3 bits, wrapping 7→0 at end of byte. Phase counter is $clog2 of the largest parameter; no overflow beyond the programmed value.
- in_data/in_last changes while in_ready=0 have no effect.
- Reset mid-operation (any state):
  - Next cycle: nCS=1, SCK=0, MOSI=0, state IDLE.
  - The partial byte is discarded; no byte_done.
  - No GAP is enforced after reset.
- Simultaneous reset and accept: reset wins; the byte is not accepted.

Test Plan:
Default config for scenarios 1–5: CLK_DIV=2, CS_SETUP=2, CS_HOLD=2, CS_GAP=3.
1. Single byte 0xA5 with last=1:
   - nCS low exactly 36 cycles.
   - 8 SCK rising edges; MOSI at those edges = 1,0,1,0,0,1,0,1.
   - byte_done pulses once.
   - in_ready stays low for 3 cycles after nCS rises.
2. Bytes 0x3C (last=0) then 0xFF (last=1), in_valid held high:
   - single nCS low window of 69 cycles.
   - 16 rising edges; sampled bits 00111100 11111111.
   - two byte_done pulses.
3. Stall in NEXT (in_valid low 10 cycles between 0x81 and 0x7E):
   - nCS stays low, SCK stays low, no edges during the stall.
   - Data received = 0x81, 0x7E.
4. Reset pulse after the 3rd rising edge of 0xF0:
   - next cycle nCS=1, SCK=0, MOSI=0, no byte_done.
   - After reset drops, in_ready=1.
   - New frame 0x01 is received intact.
5. in_valid high with in_data toggling during SHIFT, HOLD and GAP:
   - no accept until IDLE/NEXT.
   - Transmitted byte equals the value present at the accept edge.
6. CLK_DIV=1, CS_SETUP=CS_HOLD=CS_GAP=1, byte 0x55 with last=1:
   - SCK period 2 cycles.
   - nCS low 18 cycles.
   - bits 01010101.

Source files
------------

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: bytes in on a valid/ready stream, serialised MSB-first
// on MOSI with SCK idling low, frames delimited by nCS with setup/hold/gap timing.
module spi_master_tx #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       MOSI,
  output logic       SCK,
  output logic       nCS,
  output logic       busy,
  output logic       byte_done
);

  // state   | meaning
  // S_IDLE  | nCS high, waiting for the first byte of a frame
  // S_SETUP | nCS low, CS_SETUP cycles before the first SCK low phase
  // S_SHIFT | 8 bits, each CLK_DIV cycles SCK low then CLK_DIV cycles SCK high
  // S_NEXT  | nCS low between bytes of a frame, waiting for the next byte
  // S_HOLD  | nCS low for CS_HOLD cycles after the last SCK falling edge
  // S_GAP   | nCS high for CS_GAP cycles before a new frame may start
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_NEXT,
    S_HOLD,
    S_GAP
  } state_t;

  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  // Phase counter is loaded with (length - 1) and counts down to zero.
  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sr_q, sr_d;
  logic             last_q, last_d;
  logic             mosi_q, mosi_d;
  logic             sck_q, sck_d;
  logic             ncs_q, ncs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  assign in_ready = ~reset & ((state_q == S_IDLE) | (state_q == S_NEXT));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    last_d  = last_q;
    mosi_d  = mosi_q;
    sck_d   = sck_q;
    ncs_d   = ncs_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          sr_d    = in_data;
          last_d  = in_last;
          mosi_d  = in_data[7];
          ncs_d   = 1'b0;
          sck_d   = 1'b0;
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          cnt_d   = DIV_LD;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!sck_q) begin
          sck_d = 1'b1;
          cnt_d = DIV_LD;
        end else begin
          // Falling edge: MOSI only ever changes here, so it is stable at every rise.
          sck_d = 1'b0;
          cnt_d = DIV_LD;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            done_d = 1'b1;
            if (last_q) begin
              state_d = S_HOLD;
              cnt_d   = HOLD_LD;
            end else begin
              state_d = S_NEXT;
            end
          end else begin
            sr_d   = {sr_q[6:0], 1'b0};
            mosi_d = sr_q[6];
          end
        end
      end

      S_NEXT: begin
        if (accept) begin
          state_d = S_SHIFT;
          cnt_d   = DIV_LD;
          bit_d   = 3'd0;
          sr_d    = in_data;
          last_d  = in_last;
          mosi_d  = in_data[7];
        end
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
          ncs_d   = 1'b1;
          mosi_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        ncs_d   = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sr_q    <= 8'd0;
      last_q  <= 1'b0;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      last_q  <= last_d;
      mosi_q  <= mosi_d;
      sck_q   <= sck_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign MOSI      = mosi_q;
  assign SCK       = sck_q;
  assign nCS       = ncs_q;
  assign busy      = busy_q;
  assign byte_done = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: stimulus pushes expected bytes and nCS window
// lengths; an SPI receiver monitor pops and compares as frames appear on the wire.
module tb_spi_master_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;
  logic       in_valid = 1'b0;
  logic       sel = 1'b0;

  logic in_valid_a, in_valid_b;
  logic rdy_a, mosi_a, sck_a, ncs_a, busy_a, bd_a;
  logic rdy_b, mosi_b, sck_b, ncs_b, busy_b, bd_b;
  logic rdy_m, mosi_m, sck_m, ncs_m, busy_m, bd_m;

  assign in_valid_a = in_valid & ~sel;
  assign in_valid_b = in_valid & sel;
  assign rdy_m  = sel ? rdy_b  : rdy_a;
  assign mosi_m = sel ? mosi_b : mosi_a;
  assign sck_m  = sel ? sck_b  : sck_a;
  assign ncs_m  = sel ? ncs_b  : ncs_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign bd_m   = sel ? bd_b   : bd_a;

  spi_master_tx #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(3)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid_a), .in_ready(rdy_a), .MOSI(mosi_a), .SCK(sck_a),
    .nCS(ncs_a), .busy(busy_a), .byte_done(bd_a)
  );

  spi_master_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut_fast (
    .clk(clk), .reset(reset), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid_b), .in_ready(rdy_b), .MOSI(mosi_b), .SCK(sck_b),
    .nCS(ncs_b), .busy(busy_b), .byte_done(bd_b)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  logic [7:0] exp_bytes[$];
  int         exp_len[$];

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Receiver monitor
  int         cyc = 0;
  int         ncs_len = 0;
  int         rx_bits = 0;
  int         bits_since_bd = 0;
  int         last_rise = 0;
  int         rise_total = 0;
  int         bd_total = 0;
  logic [7:0] rx_sr = 8'd0;
  logic       ncs_prev = 1'b1;
  logic       sck_prev = 1'b0;
  logic       mosi_prev = 1'b0;
  logic       abort_mon = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (ncs_m == 1'b0) ncs_len++;
    if (ncs_m == 1'b1 && ncs_prev == 1'b0) begin
      if (abort_mon) begin
        abort_mon = 1'b0;
      end else begin
        if (exp_len.size() == 0) chk("unexpected_frame", ncs_len, -1);
        else chk("ncs_low_len", ncs_len, exp_len.pop_front());
        chk("leftover_bits", rx_bits, 0);
      end
      ncs_len = 0;
      rx_bits = 0;
      bits_since_bd = 0;
    end
    if (sck_m && !sck_prev) begin
      if (rx_bits > 0) chk("sck_period", cyc - last_rise, sel ? 2 : 4);
      last_rise = cyc;
      rise_total++;
      rx_sr = {rx_sr[6:0], mosi_m};
      rx_bits++;
      bits_since_bd++;
      if (rx_bits == 8) begin
        if (exp_bytes.size() == 0) chk("unexpected_byte", int'(rx_sr), -1);
        else chk("rx_byte", int'(rx_sr), int'(exp_bytes.pop_front()));
        rx_bits = 0;
      end
    end
    if (sck_m && sck_prev) chk("mosi_stable_high", int'(mosi_m), int'(mosi_prev));
    if (bd_m) begin
      bd_total++;
      chk("bits_at_byte_done", bits_since_bd, 8);
      chk("sck_low_at_byte_done", int'(sck_m), 0);
      bits_since_bd = 0;
    end
    ncs_prev = ncs_m;
    sck_prev = sck_m;
    mosi_prev = mosi_m;
  end

  task automatic timeout(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: timed out waiting, got no event expected event at %0t", name, $time);
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    int k = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    in_last = l;
    while (!rdy_m && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!rdy_m) timeout("send_ready");
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!rdy_m && k < 500);
    if (!rdy_m) timeout("wait_ready");
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while ((busy_m || !rdy_m) && k < 1000);
    if (busy_m || !rdy_m) timeout("wait_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bd0, k, cnt, bad, r0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ncs", int'(ncs_a), 1);
    chk("rst_sck", int'(sck_a), 0);
    chk("rst_mosi", int'(mosi_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_byte_done", int'(bd_a), 0);
    chk("rst_in_ready", int'(rdy_a), 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", int'(rdy_a), 1);

    // 1: single byte 0xA5
    bd0 = bd_total;
    exp_bytes.push_back(8'hA5);
    exp_len.push_back(36);
    send(8'hA5, 1'b1);
    idle_in();
    k = 0;
    while (ncs_m == 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (ncs_m == 1'b0) timeout("s1_ncs_rise");
    cnt = 0;
    bad = 0;
    while (!rdy_m && cnt < 20) begin
      if (!busy_m) bad++;
      cnt++;
      @(negedge clk);
    end
    chk("s1_gap_ready_low", cnt, 3);
    chk("s1_busy_in_gap", bad, 0);
    chk("s1_busy_idle", int'(busy_m), 0);
    chk("s1_byte_done", bd_total - bd0, 1);

    // 2: back-to-back 0x3C, 0xFF
    bd0 = bd_total;
    exp_bytes.push_back(8'h3C);
    exp_bytes.push_back(8'hFF);
    exp_len.push_back(69);
    send(8'h3C, 1'b0);
    send(8'hFF, 1'b1);
    idle_in();
    wait_idle();
    chk("s2_byte_done", bd_total - bd0, 2);

    // 3: stall in NEXT
    exp_bytes.push_back(8'h81);
    exp_bytes.push_back(8'h7E);
    exp_len.push_back(80);
    send(8'h81, 1'b0);
    idle_in();
    wait_ready();
    r0 = rise_total;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sck_m != 1'b0 || ncs_m != 1'b0 || mosi_m != 1'b1) bad++;
    end
    chk("s3_stall_lines", bad, 0);
    #1;
    chk("s3_stall_edges", rise_total - r0, 0);
    send(8'h7E, 1'b1);
    idle_in();
    wait_idle();

    // 4: reset after third rising edge of 0xF0
    bd0 = bd_total;
    send(8'hF0, 1'b1);
    idle_in();
    k = 0;
    while (rx_bits != 3 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (rx_bits != 3) timeout("s4_third_edge");
    abort_mon = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("s4_ncs", int'(ncs_a), 1);
    chk("s4_sck", int'(sck_a), 0);
    chk("s4_mosi", int'(mosi_a), 0);
    chk("s4_byte_done", int'(bd_a), 0);
    chk("s4_ready_in_rst", int'(rdy_a), 0);
    reset = 1'b0;
    #1;
    chk("s4_ready_after", int'(rdy_a), 1);
    chk("s4_no_done", bd_total - bd0, 0);
    exp_bytes.push_back(8'h01);
    exp_len.push_back(36);
    send(8'h01, 1'b1);
    idle_in();
    wait_idle();
    chk("s4_done_after", bd_total - bd0, 1);

    // 5: in_data toggling while not ready
    bd0 = bd_total;
    exp_bytes.push_back(8'h96);
    exp_bytes.push_back(8'hC3);
    exp_len.push_back(36);
    exp_len.push_back(36);
    send(8'h96, 1'b1);
    cnt = 0;
    @(negedge clk);
    while (!rdy_m && cnt < 200) begin
      in_data = 8'(cnt * 37 + 11);
      in_last = cnt[0];
      cnt++;
      @(negedge clk);
    end
    in_data = 8'hC3;
    in_last = 1'b1;
    @(posedge clk);
    idle_in();
    chk("s5_not_ready_cycles", cnt, 39);
    wait_idle();
    chk("s5_byte_done", bd_total - bd0, 2);

    // 6: fastest configuration
    sel = 1'b1;
    bd0 = bd_total;
    exp_bytes.push_back(8'h55);
    exp_len.push_back(18);
    send(8'h55, 1'b1);
    idle_in();
    wait_idle();
    chk("s6_byte_done", bd_total - bd0, 1);

    repeat (4) @(negedge clk);
    chk("bytes_left", exp_bytes.size(), 0);
    chk("frames_left", exp_len.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
